// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared GPU package: arbiter FSM encodings next to the LSU state constants,
// plus the round-robin pointer helper.
package lsu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        RESPOND = 2'b10
    } arb_state_e;

    // Successor of a granted index, wrapping n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above rr_ptr_i,
// searching upward modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    always_comb begin
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int cand;
            cand = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (req_i[cand]) begin
                grant_idx_o   = IDX_W'(cand);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between per-thread LSUs.
// Optional watchdog on the memory access is enabled by defining ARB_TIMEOUT_EN.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_read_valid,
    input  logic [NUM_REQ-1:0]                 req_write_valid,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_rdata,
    output logic                               mem_read_valid,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_addr,
    output logic [DATA_BITS-1:0]               mem_wdata,
    input  logic                               mem_ready,
    input  logic [DATA_BITS-1:0]               mem_rdata,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e                         state_q;
    logic [IDX_W-1:0]                   rr_ptr_q;
    logic [IDX_W-1:0]                   gnt_q;
    logic                               is_read_q;
    logic                               mem_read_valid_q;
    logic                               mem_write_valid_q;
    logic [ADDR_BITS-1:0]               mem_addr_q;
    logic [DATA_BITS-1:0]               mem_wdata_q;
    logic [NUM_REQ-1:0]                 req_ready_q;
    logic [NUM_REQ-1:0][DATA_BITS-1:0]  req_rdata_q;

    logic [IDX_W-1:0]                   pick_idx;
    logic                               pick_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]                   wd_cnt_q;
    logic                               timeout_err_q;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i         (req_read_valid | req_write_valid),
        .rr_ptr_i      (rr_ptr_q),
        .grant_idx_o   (pick_idx),
        .grant_valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            gnt_q             <= '0;
            is_read_q         <= 1'b0;
            mem_read_valid_q  <= 1'b0;
            mem_write_valid_q <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            req_ready_q       <= '0;
            req_rdata_q       <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_q          <= '0;
            timeout_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= '0;
                    req_rdata_q <= '0;
                    if (pick_valid) begin
                        // Read takes priority when both directions are asserted.
                        gnt_q             <= pick_idx;
                        is_read_q         <= req_read_valid[pick_idx];
                        mem_read_valid_q  <= req_read_valid[pick_idx];
                        mem_write_valid_q <= ~req_read_valid[pick_idx];
                        mem_addr_q        <= req_addr[pick_idx];
                        mem_wdata_q       <= req_wdata[pick_idx];
                        rr_ptr_q          <= IDX_W'(rr_next(int'(pick_idx), NUM_REQ));
                        state_q           <= ISSUE;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt_q          <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_read_valid_q   <= 1'b0;
                        mem_write_valid_q  <= 1'b0;
                        req_ready_q[gnt_q] <= 1'b1;
                        req_rdata_q[gnt_q] <= is_read_q ? mem_rdata : '0;
                        state_q            <= RESPOND;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_read_valid_q   <= 1'b0;
                        mem_write_valid_q  <= 1'b0;
                        timeout_err_q      <= 1'b1;
                        req_ready_q[gnt_q] <= 1'b1;
                        req_rdata_q[gnt_q] <= '0;
                        state_q            <= RESPOND;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    req_ready_q <= '0;
                    req_rdata_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign req_rdata       = req_rdata_q;
    assign mem_read_valid  = mem_read_valid_q;
    assign mem_write_valid = mem_write_valid_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign busy            = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard bench for lsu_mem_arbiter: stimulus pushes expected memory and
// response transactions; a negedge monitor pops and compares them.
module tb_lsu_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        rd_v = '0;
    logic [N-1:0]        wr_v = '0;
    logic [N-1:0][AW-1:0] addr = '0;
    logic [N-1:0][DW-1:0] wdata = '0;
    logic [N-1:0]        req_ready;
    logic [N-1:0][DW-1:0] req_rdata;
    logic                mem_read_valid, mem_write_valid;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_ready = 1'b0;
    logic [DW-1:0]       mem_rdata = '0;
    logic                busy, timeout_err;

    always #5 clk = ~clk;

    lsu_mem_arbiter #(
        .NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_read_valid(rd_v), .req_write_valid(wr_v),
        .req_addr(addr), .req_wdata(wdata),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct { int idx; logic [DW-1:0] data; } rsp_t;
    typedef struct { bit rd; logic [AW-1:0] a; logic [DW-1:0] d; } mem_t;
    rsp_t rsp_q[$];
    mem_t mem_q[$];

    logic [DW-1:0] mem_model [256];
    bit mem_stall = 1'b0;
    bit mem_seen  = 1'b0;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void exp_rsp(input int idx, input logic [DW-1:0] d);
        rsp_t e;
        e.idx = idx; e.data = d;
        rsp_q.push_back(e);
    endfunction

    function automatic void exp_mem(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_t e;
        e.rd = rd; e.a = a; e.d = d;
        mem_q.push_back(e);
    endfunction

    // Monitor and memory model: both act on the falling edge.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            check("ready_onehot", $countones(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    if (rsp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_ready: got req_ready[%0d]=1 expected no pulse", i);
                    end else begin
                        rsp_t e;
                        e = rsp_q.pop_front();
                        check("ready_idx", i, e.idx);
                        check("ready_rdata", req_rdata[i], e.data);
                        $display("rsp: req %0d rdata 0x%02h", i, req_rdata[i]);
                    end
                    done_cnt++;
                end
            end
        end
        if (!(mem_read_valid || mem_write_valid) || mem_ready) begin
            mem_ready = 1'b0;
            mem_seen  = 1'b0;
        end else if (!mem_seen) begin
            mem_seen = 1'b1;
            if (mem_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_mem: got access addr 0x%02h expected none", mem_addr);
            end else begin
                mem_t e;
                e = mem_q.pop_front();
                check("mem_dir_rd", {mem_read_valid, mem_write_valid}, e.rd ? 2'b10 : 2'b01);
                check("mem_addr", mem_addr, e.a);
                if (!e.rd) check("mem_wdata", mem_wdata, e.d);
                $display("mem: %s addr 0x%02h", mem_read_valid ? "read" : "write", mem_addr);
            end
        end else if (!mem_stall) begin
            mem_ready = 1'b1;
            if (mem_read_valid) mem_rdata = mem_model[mem_addr];
            else mem_model[mem_addr] = mem_wdata;
        end
    end

    // Wait for n total completions; optionally drop each requester's valids on its ready.
    task automatic wait_done(input int n, input int budget, input bit drop);
        for (int c = 0; c < budget && done_cnt < n; c++) begin
            @(negedge clk); #1;
            if (drop)
                for (int i = 0; i < N; i++)
                    if (req_ready[i]) begin rd_v[i] = 1'b0; wr_v[i] = 1'b0; end
        end
        check("completions", done_cnt, n);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        mem_model[8'h10] = 8'hA5;
        mem_model[8'h20] = 8'h77;
        mem_model[8'h40] = 8'h11;
        mem_model[8'h50] = 8'h22;
        mem_model[8'h60] = 8'h33;
        for (int i = 0; i < N; i++) mem_model[i] = 8'hB0 + 8'(i);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_rdata", req_rdata, 0);
        check("rst_mem_rd", mem_read_valid, 0);
        check("rst_mem_wr", mem_write_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        #1 reset = 1'b0;

        // Single read with latency measurement: req 2, addr 0x10 -> 0xA5
        @(negedge clk); #1;
        addr[2] = 8'h10; rd_v[2] = 1'b1;
        exp_mem(1, 8'h10, 0); exp_rsp(2, 8'hA5);
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk); #1;
            if (lat == 1) check("busy_in_issue", busy, 1);
            if (req_ready[2]) break;
        end
        rd_v[2] = 1'b0;
        check("latency", lat, 3);

        // Write by req 1, then read back by req 3
        addr[1] = 8'h30; wdata[1] = 8'h3C; wr_v[1] = 1'b1;
        exp_mem(0, 8'h30, 8'h3C); exp_rsp(1, 8'h00);
        wait_done(2, 20, 1);
        addr[3] = 8'h30; rd_v[3] = 1'b1;
        exp_mem(1, 8'h30, 0); exp_rsp(3, 8'h3C);
        wait_done(3, 20, 1);

        // Read and write together from req 1 -> read only
        addr[1] = 8'h20; wdata[1] = 8'h5A; rd_v[1] = 1'b1; wr_v[1] = 1'b1;
        exp_mem(1, 8'h20, 0); exp_rsp(1, 8'h77);
        wait_done(4, 20, 1);

        // Move rr_ptr to 3, then requesters 0 and 3 together -> 3 first, then 0
        addr[2] = 8'h40; rd_v[2] = 1'b1;
        exp_mem(1, 8'h40, 0); exp_rsp(2, 8'h11);
        wait_done(5, 20, 1);
        addr[0] = 8'h50; addr[3] = 8'h60; rd_v[0] = 1'b1; rd_v[3] = 1'b1;
        exp_mem(1, 8'h60, 0); exp_rsp(3, 8'h33);
        exp_mem(1, 8'h50, 0); exp_rsp(0, 8'h22);
        wait_done(7, 30, 1);

        // Fairness from reset: all four hold reads -> 0,1,2,3,0
        reset = 1'b1;
        for (int i = 0; i < N; i++) addr[i] = 8'(i);
        rd_v = '1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_mem(1, 8'(k % N), 0);
            exp_rsp(k % N, 8'hB0 + 8'(k % N));
        end
        wait_done(12, 60, 0);
        rd_v = '0;

        // Reset while req 0 is stalled in ISSUE, then req 1 proceeds normally
        @(negedge clk); #1;
        mem_stall = 1'b1;
        addr[0] = 8'h10; rd_v[0] = 1'b1;
        exp_mem(1, 8'h10, 0);
        for (int c = 0; c < 10 && !mem_read_valid; c++) begin @(negedge clk); #1; end
        check("stall_mem_rd", mem_read_valid, 1);
        @(negedge clk); #1;
        check("stall_busy", busy, 1);
        check("stall_no_ready", req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_mem_rd", mem_read_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_addr", mem_addr, 0);
        rd_v[0] = 1'b0; mem_stall = 1'b0;
        @(negedge clk); #1 reset = 1'b0;
        addr[1] = 8'h20; rd_v[1] = 1'b1;
        exp_mem(1, 8'h20, 0); exp_rsp(1, 8'h77);
        wait_done(13, 20, 1);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: memory never answers -> timeout_err and rdata 0
        mem_stall = 1'b1;
        addr[2] = 8'h44; rd_v[2] = 1'b1;
        exp_mem(1, 8'h44, 0); exp_rsp(2, 8'h00);
        wait_done(14, 40, 1);
        check("timeout_err_set", timeout_err, 1);
        mem_stall = 1'b0;
        @(negedge clk);
        check("timeout_err_sticky", timeout_err, 1);
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        repeat (3) @(negedge clk);
        check("rsp_q_empty", rsp_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_arbiter.md
LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of per-thread LSU requesters sharing one data-memory channel.
REQ-002 SHALL have parameter ADDR_BITS, default 8: memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8: memory data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit, used only under ARB_TIMEOUT_EN.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 req_read_valid  input  [NUM_REQ]  per-requester read request.
REQ-008 req_write_valid  input  [NUM_REQ]  per-requester write request.
REQ-009 req_addr  input  [NUM_REQ][ADDR_BITS]  per-requester address.
REQ-010 req_wdata  input  [NUM_REQ][DATA_BITS]  per-requester write data.
REQ-011 req_ready  output  [NUM_REQ]  one-cycle completion pulse to the granted requester.
REQ-012 req_rdata  output  [NUM_REQ][DATA_BITS]  read data, valid while that requester's req_ready is high.
REQ-013 mem_read_valid / mem_write_valid  output  1 each  memory channel request.
REQ-014 mem_addr / mem_wdata  output  ADDR_BITS / DATA_BITS  memory channel address and write data.
REQ-015 mem_ready  input  1  memory completion; mem_rdata  input  DATA_BITS  read data, valid with mem_ready.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  sticky watchdog flag; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-018 SHALL implement a registered FSM with states IDLE, ISSUE, RESPOND.
REQ-019 In IDLE, if any requester has read or write valid, SHALL grant exactly one requester, latch its index, address, data and direction, and enter ISSUE on the next edge.
REQ-020 Grant selection SHALL be round-robin: search from rr_ptr upward modulo NUM_REQ; after a grant, rr_ptr SHALL become (grant+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-021 If a requester asserts read and write valid together, SHALL perform a read.
REQ-022 In ISSUE, SHALL drive mem_read_valid or mem_write_valid (registered) from the latched direction, with the latched mem_addr and mem_wdata, and hold them stable until mem_ready is sampled high.
REQ-023 On sampling mem_ready high in ISSUE, SHALL deassert the memory valids, latch mem_rdata for reads, and enter RESPOND.
REQ-024 In RESPOND, SHALL assert req_ready only for the granted index for exactly one cycle, with req_rdata valid for that index, then return to IDLE.
REQ-025 A requester SHALL deassert its valid in the cycle after seeing req_ready, so IDLE never re-grants a completed request.
REQ-026 Requests arriving while busy SHALL wait; the arbiter SHALL NOT drop them or change the latched transaction.
REQ-027 mem_ready sampled outside ISSUE SHALL be ignored.
REQ-028 Minimum latency is 3 cycles from valid sampled in IDLE to req_ready, with mem_ready high one cycle after mem valid.

Reset
REQ-029 On reset, state SHALL go to IDLE, rr_ptr to 0, and all outputs to 0 (req_ready, req_rdata, mem valids, mem_addr, mem_wdata, busy, timeout_err).
REQ-030 Reset mid-transaction SHALL abandon the outstanding memory access without a req_ready pulse.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN: when defined, a counter SHALL run in ISSUE. If it reaches TIMEOUT_CYCLES without mem_ready, the arbiter SHALL deassert the mem valids, set timeout_err (sticky until reset), and enter RESPOND with req_rdata = 0.
REQ-032 Without ARB_TIMEOUT_EN, the arbiter SHALL have no counter, ISSUE SHALL wait indefinitely, and timeout_err SHALL be constant 0.

Structure
REQ-033 FSM state encodings (IDLE=2'b00, ISSUE=2'b01, RESPOND=2'b10) SHALL live in the shared gpu package alongside the LSU state constants.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, rr_ptr; outputs: grant index, grant_valid).

Verification
REQ-035 Single read: req 2 reads addr 0x10, memory returns 0xA5 after 1 cycle -> mem_read_valid with addr 0x10, then req_ready[2] for 1 cycle with req_rdata[2]=0xA5.
REQ-036 Fairness: all 4 requesters hold reads continuously from reset -> grant order 0,1,2,3,0.
REQ-037 Wrap: rr_ptr=3, requesters 0 and 3 valid -> 3 is granted first, then 0.
REQ-038 Write and read together: req 1 asserts both with addr 0x20, wdata 0x5A -> only mem_read_valid is asserted.
REQ-039 Reset during ISSUE for req 0 -> next cycle all outputs are 0, no req_ready; a new request from req 1 is granted normally.
REQ-040 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held 0 -> after 8 ISSUE cycles, timeout_err=1 and req_ready pulses with rdata 0x00.
